// File: rtl/ofifo_row.sv
// Output buffer behind mac_row: one FIFO per column. Columns are written on
// skewed cycles, and a single read pops every column together into one aligned psum word.
module ofifo_row #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_valid,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    localparam int aw = $clog2(depth);

    logic [aw:0]            wr_ptr_q [col];
    logic [aw:0]            wr_ptr_d [col];
    logic [aw:0]            rd_ptr_q [col];
    logic [aw:0]            rd_ptr_d [col];
    logic [psum_bw-1:0]     mem_q    [col][depth];

    logic [col-1:0]         empty_s;
    logic [col-1:0]         full_s;
    logic [col-1:0]         wr_acc_s;
    logic                   rd_acc_s;
    logic [psum_bw*col-1:0] head_s;
    logic [psum_bw*col-1:0] out_q;
    logic [psum_bw*col-1:0] out_d;
    logic                   out_valid_q;
    logic                   out_valid_d;
    logic                   overflow_q;
    logic                   overflow_d;

    // Per-column status flags and head-of-queue data, derived from the pointers.
    always_comb begin
        empty_s = '0;
        full_s  = '0;
        head_s  = '0;
        for (int c = 0; c < col; c++) begin
            empty_s[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            full_s[c]  = (wr_ptr_q[c][aw-1:0] == rd_ptr_q[c][aw-1:0]) &&
                         (wr_ptr_q[c][aw] != rd_ptr_q[c][aw]);
            head_s[c*psum_bw +: psum_bw] = mem_q[c][rd_ptr_q[c][aw-1:0]];
        end
    end

    assign o_valid    = ~|empty_s;
    assign o_full     = |full_s;
    assign o_ready    = ~o_full;
    assign rd_acc_s   = rd & o_valid;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign o_overflow = overflow_q;

    // Next-state logic. An accepted read frees the head slot at the same edge,
    // so a full column may still take a write in that cycle.
    always_comb begin
        wr_acc_s = '0;
        for (int c = 0; c < col; c++) begin
            wr_acc_s[c] = wr[c] & (~full_s[c] | rd_acc_s);
            if (wr_acc_s[c]) begin
                wr_ptr_d[c] = wr_ptr_q[c] + {{aw{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d[c] = wr_ptr_q[c];
            end
            if (rd_acc_s) begin
                rd_ptr_d[c] = rd_ptr_q[c] + {{aw{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d[c] = rd_ptr_q[c];
            end
        end
        if (rd_acc_s) begin
            out_d = head_s;
        end else begin
            out_d = out_q;
        end
        out_valid_d = rd_acc_s;
        overflow_d  = overflow_q | (|(wr & ~wr_acc_s));
    end

    // Pointer, output and error-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_acc_s[c]) begin
                mem_q[c][wr_ptr_q[c][aw-1:0]] <= in[c*psum_bw +: psum_bw];
            end
        end
    end

endmodule
